menu_fsm_n: RTL and testbench

MENU_FSM_N -- requirements
Module: menu_fsm_n

---
 rtl/menu_fsm_n.sv | 257 +++++++++++++++++++++++++
 tb/tb_menu_fsm_n.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_fsm_n.sv
// -----------------------------------------------------------------------------
// menu_fsm_n : game menu navigation state machine
//
// Walks a player through TITLE -> CAR_SELECT -> CONTROL_SELECT -> GAME, with
// PAUSE reachable from GAME. Four pre-synchronised button levels are turned
// into single rising-edge events, one event per cycle is chosen by priority
// (U > D > R > L) and that event drives the menu one cycle later. All
// outputs are registered.
//
// Ports
//   pclk                     in   1   clock, rising edge
//   rst_n                    in   1   synchronous active-low reset
//   btnR/btnL/btnU/btnD      in   1   next / previous / confirm / back levels
//   title_screen_visible     out  1   screen enables (exactly one high)
//   car_select_visible       out  1
//   control_select_visible   out  1
//   game_visible             out  1
//   pause_visible            out  1
//   arrow_visible            out  1   selection arrow enable
//   arrow_xpos, arrow_ypos   out  11  arrow top-left position
//   car                      out  CW  confirmed car index
//   control                  out  KW  confirmed control index
//   game_start               out  1   one-cycle pulse on CONTROL_SELECT -> GAME
// -----------------------------------------------------------------------------
module menu_fsm_n #(
  parameter int N_CARS  = 4,
  parameter int N_CTRL  = 2,
  parameter int CAR_X0  = 208,
  parameter int CAR_DX  = 192,
  parameter int CAR_Y   = 480,
  parameter int CTRL_X0 = 256,
  parameter int CTRL_DX = 384,
  parameter int CTRL_Y  = 576,
  localparam int CW = (N_CARS > 2) ? $clog2(N_CARS) : 1,
  localparam int KW = (N_CTRL > 2) ? $clog2(N_CTRL) : 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          btnR,
  input  logic          btnL,
  input  logic          btnU,
  input  logic          btnD,
  output logic          title_screen_visible,
  output logic          car_select_visible,
  output logic          control_select_visible,
  output logic          game_visible,
  output logic          pause_visible,
  output logic          arrow_visible,
  output logic [10:0]   arrow_xpos,
  output logic [10:0]   arrow_ypos,
  output logic [CW-1:0] car,
  output logic [KW-1:0] control,
  output logic          game_start
);

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_CAR_SEL  = 3'd1,
    S_CTRL_SEL = 3'd2,
    S_GAME     = 3'd3,
    S_PAUSE    = 3'd4
  } state_t;

  // Event vector bit positions: {U, D, R, L}
  localparam int EV_U = 3;
  localparam int EV_D = 2;
  localparam int EV_R = 1;
  localparam int EV_L = 0;

  localparam logic [CW-1:0] CAR_LAST  = CW'(N_CARS - 1);
  localparam logic [KW-1:0] CTRL_LAST = KW'(N_CTRL - 1);

  state_t        r_state;
  logic [3:0]    r_prev;
  logic [3:0]    r_ev;
  logic [CW-1:0] r_car_cur;
  logic [KW-1:0] r_ctl_cur;

  logic [3:0]    w_btn;
  logic [3:0]    w_rise;
  logic [3:0]    w_ev_nx;
  state_t        w_state_nx;
  logic [CW-1:0] w_car_cur_nx;
  logic [KW-1:0] w_ctl_cur_nx;
  logic [CW-1:0] w_car_nx;
  logic [KW-1:0] w_ctl_nx;
  logic          w_gs_nx;
  logic          w_arrow_vis_nx;
  logic [10:0]   w_ax_nx;
  logic [10:0]   w_ay_nx;

  // Arrow coordinate: origin plus index times pitch, wrapped to 11 bits.
  function automatic logic [10:0] arrow_pos(input int base, input int pitch, input int idx);
    logic [31:0] sum;
    sum = 32'(base + idx * pitch);
    return sum[10:0];
  endfunction

  assign w_btn  = {btnU, btnD, btnR, btnL};
  assign w_rise = w_btn & ~r_prev;

  // Keep only the highest-priority rising edge (U > D > R > L).
  always_comb begin
    w_ev_nx = 4'b0000;
    if (w_rise[EV_U]) begin
      w_ev_nx = 4'b1000;
    end else if (w_rise[EV_D]) begin
      w_ev_nx = 4'b0100;
    end else if (w_rise[EV_R]) begin
      w_ev_nx = 4'b0010;
    end else if (w_rise[EV_L]) begin
      w_ev_nx = 4'b0001;
    end else begin
      w_ev_nx = 4'b0000;
    end
  end

  // Menu transitions driven by the event registered on the previous edge.
  always_comb begin
    w_state_nx   = r_state;
    w_car_cur_nx = r_car_cur;
    w_ctl_cur_nx = r_ctl_cur;
    w_car_nx     = car;
    w_ctl_nx     = control;
    w_gs_nx      = 1'b0;
    case (r_state)
      S_TITLE: begin
        if (r_ev[EV_U]) begin
          w_state_nx   = S_CAR_SEL;
          w_car_cur_nx = {CW{1'b0}};
        end else begin
          w_state_nx = S_TITLE;
        end
      end
      S_CAR_SEL: begin
        if (r_ev[EV_U]) begin
          w_car_nx     = r_car_cur;
          w_ctl_cur_nx = {KW{1'b0}};
          w_state_nx   = S_CTRL_SEL;
        end else if (r_ev[EV_D]) begin
          w_state_nx = S_TITLE;
        end else if (r_ev[EV_R]) begin
          w_car_cur_nx = (r_car_cur == CAR_LAST) ? {CW{1'b0}} : r_car_cur + 1'b1;
        end else if (r_ev[EV_L]) begin
          w_car_cur_nx = (r_car_cur == {CW{1'b0}}) ? CAR_LAST : r_car_cur - 1'b1;
        end else begin
          w_state_nx = S_CAR_SEL;
        end
      end
      S_CTRL_SEL: begin
        if (r_ev[EV_U]) begin
          w_ctl_nx   = r_ctl_cur;
          w_state_nx = S_GAME;
          w_gs_nx    = 1'b1;
        end else if (r_ev[EV_D]) begin
          // Going back re-points the car cursor at the confirmed car.
          w_state_nx   = S_CAR_SEL;
          w_car_cur_nx = car;
        end else if (r_ev[EV_R]) begin
          w_ctl_cur_nx = (r_ctl_cur == CTRL_LAST) ? {KW{1'b0}} : r_ctl_cur + 1'b1;
        end else if (r_ev[EV_L]) begin
          w_ctl_cur_nx = (r_ctl_cur == {KW{1'b0}}) ? CTRL_LAST : r_ctl_cur - 1'b1;
        end else begin
          w_state_nx = S_CTRL_SEL;
        end
      end
      S_GAME: begin
        if (r_ev[EV_D]) begin
          w_state_nx = S_PAUSE;
        end else begin
          w_state_nx = S_GAME;
        end
      end
      S_PAUSE: begin
        if (r_ev[EV_U]) begin
          w_state_nx = S_GAME;
        end else if (r_ev[EV_D]) begin
          w_state_nx   = S_TITLE;
          w_car_nx     = {CW{1'b0}};
          w_ctl_nx     = {KW{1'b0}};
          w_car_cur_nx = {CW{1'b0}};
          w_ctl_cur_nx = {KW{1'b0}};
        end else begin
          w_state_nx = S_PAUSE;
        end
      end
      default: begin
        w_state_nx = S_TITLE;
      end
    endcase
  end

  // Arrow enable and position follow the upcoming state and cursors.
  always_comb begin
    w_arrow_vis_nx = 1'b0;
    w_ax_nx        = 11'd0;
    w_ay_nx        = 11'd0;
    case (w_state_nx)
      S_CAR_SEL: begin
        w_arrow_vis_nx = 1'b1;
        w_ax_nx        = arrow_pos(CAR_X0, CAR_DX, int'(w_car_cur_nx));
        w_ay_nx        = 11'(CAR_Y);
      end
      S_CTRL_SEL: begin
        w_arrow_vis_nx = 1'b1;
        w_ax_nx        = arrow_pos(CTRL_X0, CTRL_DX, int'(w_ctl_cur_nx));
        w_ay_nx        = 11'(CTRL_Y);
      end
      default: begin
        w_arrow_vis_nx = 1'b0;
        w_ax_nx        = 11'd0;
        w_ay_nx        = 11'd0;
      end
    endcase
  end

  // State, event pipeline and registered outputs.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      // Previous levels start high so a button held through reset is not an event.
      r_prev                 <= 4'b1111;
      r_ev                   <= 4'b0000;
      r_state                <= S_TITLE;
      r_car_cur              <= {CW{1'b0}};
      r_ctl_cur              <= {KW{1'b0}};
      car                    <= {CW{1'b0}};
      control                <= {KW{1'b0}};
      game_start             <= 1'b0;
      title_screen_visible   <= 1'b1;
      car_select_visible     <= 1'b0;
      control_select_visible <= 1'b0;
      game_visible           <= 1'b0;
      pause_visible          <= 1'b0;
      arrow_visible          <= 1'b0;
      arrow_xpos             <= 11'd0;
      arrow_ypos             <= 11'd0;
    end else begin
      r_prev                 <= w_btn;
      r_ev                   <= w_ev_nx;
      r_state                <= w_state_nx;
      r_car_cur              <= w_car_cur_nx;
      r_ctl_cur              <= w_ctl_cur_nx;
      car                    <= w_car_nx;
      control                <= w_ctl_nx;
      game_start             <= w_gs_nx;
      title_screen_visible   <= (w_state_nx == S_TITLE);
      car_select_visible     <= (w_state_nx == S_CAR_SEL);
      control_select_visible <= (w_state_nx == S_CTRL_SEL);
      game_visible           <= (w_state_nx == S_GAME);
      pause_visible          <= (w_state_nx == S_PAUSE);
      arrow_visible          <= w_arrow_vis_nx;
      arrow_xpos             <= w_ax_nx;
      arrow_ypos             <= w_ay_nx;
    end
  end

endmodule

// File: tb/tb_menu_fsm_n.sv
// -----------------------------------------------------------------------------
// tb_menu_fsm_n : scoreboard bench for menu_fsm_n
//
// Two instances share the same buttons and reset: the default build
// (4 cars, 2 controls) and a 3-car / 3-control build. A reference model of
// the menu rules pushes the expected outputs for every edge into a queue per
// instance; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_menu_fsm_n;

  localparam int M_TITLE = 0;
  localparam int M_CAR   = 1;
  localparam int M_CTRL  = 2;
  localparam int M_GAME  = 3;
  localparam int M_PAUSE = 4;

  typedef struct {
    int vis;
    int av;
    int ax;
    int ay;
    int car;
    int ctl;
    int gs;
  } exp_t;

  logic pclk;
  logic rst_n;
  logic btnR, btnL, btnU, btnD;

  logic       tv0, cv0, kv0, gv0, pv0, av0, gs0;
  logic [10:0] ax0, ay0;
  logic [1:0] car0;
  logic [0:0] ctl0;

  logic       tv1, cv1, kv1, gv1, pv1, av1, gs1;
  logic [10:0] ax1, ay1;
  logic [1:0] car1;
  logic [1:0] ctl1;

  int checks;
  int failures;

  exp_t q0[$];
  exp_t q1[$];

  // model state, one slot per instance
  int n_cars [2] = '{4, 3};
  int n_ctrl [2] = '{2, 3};
  int m_state[2];
  int m_ccur [2];
  int m_kcur [2];
  int m_car  [2];
  int m_ctl  [2];
  int m_gs   [2];
  int pend;
  logic [3:0] prev;

  menu_fsm_n u_dut0 (
    .pclk(pclk), .rst_n(rst_n),
    .btnR(btnR), .btnL(btnL), .btnU(btnU), .btnD(btnD),
    .title_screen_visible(tv0), .car_select_visible(cv0),
    .control_select_visible(kv0), .game_visible(gv0), .pause_visible(pv0),
    .arrow_visible(av0), .arrow_xpos(ax0), .arrow_ypos(ay0),
    .car(car0), .control(ctl0), .game_start(gs0)
  );

  menu_fsm_n #(.N_CARS(3), .N_CTRL(3)) u_dut1 (
    .pclk(pclk), .rst_n(rst_n),
    .btnR(btnR), .btnL(btnL), .btnU(btnU), .btnD(btnD),
    .title_screen_visible(tv1), .car_select_visible(cv1),
    .control_select_visible(kv1), .game_visible(gv1), .pause_visible(pv1),
    .arrow_visible(av1), .arrow_xpos(ax1), .arrow_ypos(ay1),
    .car(car1), .control(ctl1), .game_start(gs1)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset(input int k);
    m_state[k] = M_TITLE;
    m_ccur[k]  = 0;
    m_kcur[k]  = 0;
    m_car[k]   = 0;
    m_ctl[k]   = 0;
    m_gs[k]    = 0;
  endfunction

  // ev: 0 none, 1 U, 2 D, 3 R, 4 L
  function automatic void model_apply(input int k, input int ev);
    int nc = n_cars[k];
    int nk = n_ctrl[k];
    m_gs[k] = 0;
    case (m_state[k])
      M_TITLE: if (ev == 1) begin m_state[k] = M_CAR; m_ccur[k] = 0; end
      M_CAR: begin
        if (ev == 1) begin m_car[k] = m_ccur[k]; m_kcur[k] = 0; m_state[k] = M_CTRL; end
        else if (ev == 2) m_state[k] = M_TITLE;
        else if (ev == 3) m_ccur[k] = (m_ccur[k] + 1) % nc;
        else if (ev == 4) m_ccur[k] = (m_ccur[k] + nc - 1) % nc;
      end
      M_CTRL: begin
        if (ev == 1) begin m_ctl[k] = m_kcur[k]; m_state[k] = M_GAME; m_gs[k] = 1; end
        else if (ev == 2) begin m_state[k] = M_CAR; m_ccur[k] = m_car[k]; end
        else if (ev == 3) m_kcur[k] = (m_kcur[k] + 1) % nk;
        else if (ev == 4) m_kcur[k] = (m_kcur[k] + nk - 1) % nk;
      end
      M_GAME: if (ev == 2) m_state[k] = M_PAUSE;
      M_PAUSE: begin
        if (ev == 1) m_state[k] = M_GAME;
        else if (ev == 2) begin model_reset(k); end
      end
      default: m_state[k] = M_TITLE;
    endcase
  endfunction

  function automatic exp_t model_expect(input int k);
    exp_t e;
    e.vis = 16 >> m_state[k];
    e.av  = 0;
    e.ax  = 0;
    e.ay  = 0;
    if (m_state[k] == M_CAR) begin
      e.av = 1; e.ax = (208 + m_ccur[k] * 192) % 2048; e.ay = 480;
    end else if (m_state[k] == M_CTRL) begin
      e.av = 1; e.ax = (256 + m_kcur[k] * 384) % 2048; e.ay = 576;
    end
    e.car = m_car[k];
    e.ctl = m_ctl[k];
    e.gs  = m_gs[k];
    return e;
  endfunction

  // Reference model: on every edge compute what each DUT should show next.
  initial begin
    logic [3:0] b;
    logic [3:0] rise;
    pend = 0;
    prev = 4'b1111;
    forever begin
      @(posedge pclk);
      b = {btnU, btnD, btnR, btnL};
      if (!rst_n) begin
        model_reset(0);
        model_reset(1);
        pend = 0;
        prev = 4'b1111;
      end else begin
        model_apply(0, pend);
        model_apply(1, pend);
        rise = b & ~prev;
        if (rise[3]) pend = 1;
        else if (rise[2]) pend = 2;
        else if (rise[1]) pend = 3;
        else if (rise[0]) pend = 4;
        else pend = 0;
        prev = b;
      end
      q0.push_back(model_expect(0));
      q1.push_back(model_expect(1));
    end
  end

  // Monitor: compare DUT outputs against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_vis", int'({tv0, cv0, kv0, gv0, pv0}), e.vis);
        chk("d0_arrow_vis", int'(av0), e.av);
        chk("d0_arrow_x", int'(ax0), e.ax);
        chk("d0_arrow_y", int'(ay0), e.ay);
        chk("d0_car", int'(car0), e.car);
        chk("d0_control", int'(ctl0), e.ctl);
        chk("d0_game_start", int'(gs0), e.gs);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_vis", int'({tv1, cv1, kv1, gv1, pv1}), e.vis);
        chk("d1_arrow_vis", int'(av1), e.av);
        chk("d1_arrow_x", int'(ax1), e.ax);
        chk("d1_arrow_y", int'(ay1), e.ay);
        chk("d1_car", int'(car1), e.car);
        chk("d1_control", int'(ctl1), e.ctl);
        chk("d1_game_start", int'(gs1), e.gs);
      end
    end
  end

  task automatic set_btn(input logic [3:0] b);
    {btnU, btnD, btnR, btnL} = b;
  endtask

  // Press a button combination for one cycle, then release for two.
  task automatic press(input logic [3:0] b);
    set_btn(b);
    @(negedge pclk);
    set_btn(4'b0000);
    repeat (2) @(negedge pclk);
  endtask

  // Stimulus: directed menu walks, then randomized buttons and resets.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_btn(4'b0000);
    repeat (3) @(negedge pclk);

    // btnU held through reset release: no event until re-pressed
    set_btn(4'b1000);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    repeat (5) @(negedge pclk);
    set_btn(4'b0000);
    @(negedge pclk);

    press(4'b1000);                      // TITLE -> CAR_SELECT
    repeat (4) press(4'b0010);           // 4x R, wraps both instances
    press(4'b0001);                      // L at 0 (default build: cursor 0 again)
    press(4'b0001);                      // L wrap
    press(4'b1000);                      // confirm car
    press(4'b0010);                      // R
    press(4'b1000);                      // confirm control, game_start
    press(4'b0100);                      // pause
    press(4'b0100);                      // back to title, car/control cleared

    set_btn(4'b1000);                    // U held 10 cycles: one transition
    repeat (10) @(negedge pclk);
    set_btn(4'b0000);
    repeat (2) @(negedge pclk);
    press(4'b1010);                      // U and R together: confirm only
    press(4'b0100);                      // back to CAR_SELECT
    press(4'b0001);
    press(4'b1000);                      // reach CONTROL_SELECT
    set_btn(4'b1000);                    // U, then reset on the acting edge
    @(negedge pclk);
    set_btn(4'b0000);
    rst_n = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);

    for (int i = 0; i < 3000; i++) begin
      set_btn({($urandom_range(3) == 0), ($urandom_range(5) == 0),
               ($urandom_range(2) == 0), ($urandom_range(2) == 0)});
      rst_n = ($urandom_range(99) != 0);
      @(negedge pclk);
    end
    rst_n = 1'b1;
    set_btn(4'b0000);
    repeat (4) @(negedge pclk);
    #1;
    if (q0.size() > 1 || q1.size() > 1) begin
      chk("queue_drain", q0.size() + q1.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
